// File: rtl/mul_ser_pkg.sv
// Shared definitions for the serial multiplier link: state encodings and default operand width.
package mul_ser_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;
    localparam int unsigned STATE_W       = 2;

    typedef logic [STATE_W-1:0] ser_state_t;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] START     = 2'd1;
    localparam logic [1:0] SHIFT     = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;

endpackage

// File: rtl/mul_piso_shreg.sv
// Parallel-load, shift-left shift register presenting its MSB as the serial bit.
module mul_piso_shreg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    output logic             msb_c
);

    logic [WIDTH-1:0] shreg_q;

    // Load wins over shift so a fresh operand pair is never corrupted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
        end else if (load) begin
            shreg_q <= load_data;
        end else if (shift_en) begin
            shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
        end
    end

    assign msb_c = shreg_q[WIDTH-1];

endmodule

// File: rtl/mul_operand_serializer.sv
// Serializes an operand pair (A then B, MSB first) to the multiplier and waits for its done flag.
module mul_operand_serializer
    import mul_ser_pkg::*;
#(
    parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             ser_start,
    output logic             ser_in,
    input  logic             mul_done,
    output logic             busy,
    output logic             txn_done,
    output logic             timeout
);

    localparam int unsigned SHREG_W = 2 * WIDTH;
    localparam int unsigned BIT_CW  = $clog2(SHREG_W);
    localparam int unsigned WAIT_CW = $clog2(TIMEOUT + 1);

    localparam logic [BIT_CW-1:0]  LAST_BIT  = BIT_CW'(SHREG_W - 1);
    localparam logic [WAIT_CW-1:0] LAST_WAIT = WAIT_CW'(TIMEOUT - 1);

    ser_state_t         state_q, state_d;
    logic [BIT_CW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WAIT_CW-1:0] wait_cnt_q, wait_cnt_d;
    logic               ser_start_d, ser_in_d, busy_d, txn_done_d, timeout_d;
    logic               load, shift_en, shreg_msb_c;

    mul_piso_shreg #(
        .WIDTH (SHREG_W)
    ) u_shreg (
        .clk       (clk),
        .rst_n     (reset_n),
        .load      (load),
        .load_data ({op_a, op_b}),
        .shift_en  (shift_en),
        .msb_c     (shreg_msb_c)
    );

    assign op_ready = (state_q == IDLE);

    // Next-state, counters and next values of the registered outputs.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = '0;
        wait_cnt_d = '0;
        txn_done_d = 1'b0;
        timeout_d  = 1'b0;
        load       = 1'b0;

        case (state_q)
            IDLE: begin
                if (op_valid) begin
                    load    = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                state_d = SHIFT;
            end
            SHIFT: begin
                if (bit_cnt_q == LAST_BIT) begin
                    state_d = WAIT_DONE;
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_CW'(1);
                end
            end
            WAIT_DONE: begin
                // A done flag in the final wait cycle still counts as success.
                if (mul_done) begin
                    txn_done_d = 1'b1;
                    state_d    = IDLE;
                end else if (wait_cnt_q == LAST_WAIT) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Bit shown next cycle is the current MSB, consumed by the same edge.
        shift_en    = (state_d == SHIFT);
        ser_in_d    = shift_en & shreg_msb_c;
        ser_start_d = (state_d == START);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            wait_cnt_q <= '0;
            ser_start  <= 1'b0;
            ser_in     <= 1'b0;
            busy       <= 1'b0;
            txn_done   <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            ser_start  <= ser_start_d;
            ser_in     <= ser_in_d;
            busy       <= busy_d;
            txn_done   <= txn_done_d;
            timeout    <= timeout_d;
        end
    end

endmodule
